// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
//   Bundles the three conversations of the ALU op sequencer:
//     - request  : issue stage -> sequencer (valid/ready + funct/operands)
//     - ALU      : sequencer <-> single-cycle integer ALU
//     - response : sequencer -> writeback (valid/ready + result)
//   slave  : the sequencer's view
//   master : the surrounding core's view (issue stage, ALU, writeback)
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int XLEN = 32
);
  // request side
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic            req_funct7b5;
  logic [XLEN-1:0] req_op_a;
  logic [XLEN-1:0] req_op_b;

  // ALU side
  logic [3:0]      alu_opcode;
  logic [XLEN-1:0] alu_input_a;
  logic [XLEN-1:0] alu_input_b;
  logic [XLEN-1:0] alu_output;
  logic            alu_neg;
  logic            alu_zero;

  // response side
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;

  modport slave (
    input  req_valid, req_funct3, req_funct7b5, req_op_a, req_op_b,
    output req_ready,
    output alu_opcode, alu_input_a, alu_input_b,
    input  alu_output, alu_neg, alu_zero,
    output rsp_valid, rsp_result,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_funct3, req_funct7b5, req_op_a, req_op_b,
    input  req_ready,
    input  alu_opcode, alu_input_a, alu_input_b,
    output alu_output, alu_neg, alu_zero,
    input  rsp_valid, rsp_result,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//   Front-end controller for the single-cycle integer ALU. Accepts one RV32I
//   register/immediate arithmetic op per request handshake, decodes
//   funct3/funct7[5] into the ALU opcode and produces the final result:
//     ADD/SUB/XOR/OR/AND : straight from the ALU
//     SLT/SLTU           : from operand signs and the ALU SUB sign flag
//     SLL/SRL/SRA        : shifted iteratively here, SHIFT_STEP bits/cycle
//
// Parameters
//   XLEN       datapath width (only 32 supported)
//   SHIFT_STEP bits shifted per cycle in SHIFT (1, 2, 4 or 8)
//
// Ports
//   clk    core clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   flush  synchronous abort of any in-flight op (result register kept)
//   busy   high whenever the sequencer is not IDLE
//   bus    request / ALU / response signals (alu_op_sequencer_if.slave)
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  output logic                   busy,
  alu_op_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b1000;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  // funct3 -> ALU opcode. Shifts never reach the ALU, so they map to ADD
  // (the idle encoding).
  function automatic logic [3:0] f_decode(input logic [2:0] funct3,
                                          input logic       funct7b5);
    logic [3:0] opc;
    opc = OP_ADD;
    case (funct3)
      3'b000:         opc = funct7b5 ? OP_SUB : OP_ADD;
      3'b010, 3'b011: opc = OP_SUB;
      3'b100:         opc = OP_XOR;
      3'b110:         opc = OP_OR;
      3'b111:         opc = OP_AND;
      default:        opc = OP_ADD;
    endcase
    return opc;
  endfunction

  state_t            r_state;
  state_t            w_next_state;

  logic [2:0]        r_funct3;
  logic              r_funct7b5;
  logic              r_op_a_msb;
  logic              r_op_b_msb;
  logic [XLEN-1:0]   r_shift;
  logic [4:0]        r_count;
  logic [3:0]        r_alu_opcode;
  logic [XLEN-1:0]   r_alu_a;
  logic [XLEN-1:0]   r_alu_b;
  logic [XLEN-1:0]   r_rsp_result;

  logic              w_accept;
  logic              w_req_is_shift;
  logic [4:0]        w_step;
  logic              w_fill;
  logic [2*XLEN-1:0] w_wide;
  logic [XLEN-1:0]   w_shift_next;
  logic [XLEN-1:0]   w_exec_result;
  logic              w_unused_alu_zero;

  assign w_accept          = bus.req_valid && bus.req_ready;
  assign w_req_is_shift    = (bus.req_funct3[1:0] == 2'b01);
  assign w_unused_alu_zero = bus.alu_zero;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred for combinational outputs.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next_state = w_req_is_shift ? S_SHIFT : S_EXEC;
        S_EXEC:  w_next_state = S_DONE;
        S_SHIFT: if (r_count == 5'd0) w_next_state = S_DONE;
        S_DONE:  if (bus.rsp_ready) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = (r_state == S_IDLE) && !flush;
    bus.rsp_valid = (r_state == S_DONE);
    busy          = (r_state != S_IDLE);
  end

  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.alu_input_a = r_alu_a;
  assign bus.alu_input_b = r_alu_b;
  assign bus.rsp_result  = r_rsp_result;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Partial step only on the last iteration when count < SHIFT_STEP.
  assign w_step = (r_count < STEP) ? r_count : STEP;

  // Right shifts go through a double-width vector whose upper half is the
  // fill bit: zeros for SRL, original op_a[31] for SRA.
  assign w_fill = r_funct7b5 && (r_funct3 == 3'b101) && r_op_a_msb;
  assign w_wide = {{XLEN{w_fill}}, r_shift} >> w_step;

  assign w_shift_next = (r_funct3 == 3'b001) ? (r_shift << w_step)
                                             : w_wide[XLEN-1:0];

  // SLT/SLTU: with differing signs the answer is decided by the signs alone
  // (SUB would overflow); with equal signs the SUB result sign is exact.
  always_comb begin
    w_exec_result = bus.alu_output;
    case (r_funct3)
      3'b010: w_exec_result = {{(XLEN-1){1'b0}},
                               (r_op_a_msb != r_op_b_msb) ? r_op_a_msb : bus.alu_neg};
      3'b011: w_exec_result = {{(XLEN-1){1'b0}},
                               (r_op_a_msb != r_op_b_msb) ? r_op_b_msb : bus.alu_neg};
      default: w_exec_result = bus.alu_output;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3     <= '0;
      r_funct7b5   <= 1'b0;
      r_op_a_msb   <= 1'b0;
      r_op_b_msb   <= 1'b0;
      r_shift      <= '0;
      r_count      <= '0;
      r_alu_opcode <= OP_ADD;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_result <= '0;
    end else begin
      // ALU drive is registered and only non-zero for the EXEC cycle; EXEC is
      // entered solely from an IDLE accept, so the request fields are the
      // source.
      if (w_next_state == S_EXEC) begin
        r_alu_opcode <= f_decode(bus.req_funct3, bus.req_funct7b5);
        r_alu_a      <= bus.req_op_a;
        r_alu_b      <= bus.req_op_b;
      end else begin
        r_alu_opcode <= OP_ADD;
        r_alu_a      <= '0;
        r_alu_b      <= '0;
      end

      if (r_state == S_IDLE && w_accept) begin
        r_funct3   <= bus.req_funct3;
        r_funct7b5 <= bus.req_funct7b5;
        r_op_a_msb <= bus.req_op_a[XLEN-1];
        r_op_b_msb <= bus.req_op_b[XLEN-1];
        r_shift    <= bus.req_op_a;
        r_count    <= bus.req_op_b[4:0];
      end

      // flush abandons the op without touching the last delivered result.
      if (!flush) begin
        case (r_state)
          S_EXEC: r_rsp_result <= w_exec_result;
          S_SHIFT: begin
            if (r_count == 5'd0) begin
              r_rsp_result <= r_shift;
            end else begin
              r_shift <= w_shift_next;
              r_count <= r_count - w_step;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int XLEN       = 32;
  localparam int SHIFT_STEP = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_result = '0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.XLEN(XLEN)) bus ();

  alu_op_sequencer #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  // Behavioural single-cycle ALU
  always_comb begin
    case (bus.alu_opcode)
      4'b0000: bus.alu_output = bus.alu_input_a + bus.alu_input_b;
      4'b0100: bus.alu_output = bus.alu_input_a ^ bus.alu_input_b;
      4'b0110: bus.alu_output = bus.alu_input_a | bus.alu_input_b;
      4'b0111: bus.alu_output = bus.alu_input_a & bus.alu_input_b;
      4'b1000: bus.alu_output = bus.alu_input_a - bus.alu_input_b;
      default: bus.alu_output = 32'h0;
    endcase
    bus.alu_neg  = bus.alu_output[31];
    bus.alu_zero = (bus.alu_output == 32'h0);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic f7,
                                             input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] b);
    if (f3 == 3'd1 || f3 == 3'd5)
      return (int'(b[4:0]) + SHIFT_STEP - 1) / SHIFT_STEP + 2;
    return 2;
  endfunction

  function automatic logic [31:0] ref_opcode(input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return f7 ? 32'h8 : 32'h0;
      3'd2, 3'd3: return 32'h8;
      3'd4: return 32'h4;
      3'd6: return 32'h6;
      3'd7: return 32'h7;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b);
    bus.req_funct3   = f3;
    bus.req_funct7b5 = f7;
    bus.req_op_a     = a;
    bus.req_op_b     = b;
    bus.req_valid    = 1'b1;
  endtask

  // Leaves us at the first negedge after the accept edge, with the request
  // fields scrambled to show they are ignored once accepted.
  task automatic accept_req(input logic [2:0] f3, input logic f7,
                            input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    drive_req(f3, f7, a, b);
    #1 check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_op_a   = $urandom;
    bus.req_op_b   = $urandom;
    bus.req_funct3 = 3'($urandom_range(0, 7));
  endtask

  // Called at negedge k=1 after accept; returns at the negedge where
  // rsp_valid is first seen (or after the cycle budget expires).
  task automatic wait_rsp(input logic [31:0] exp_res, input int exp_lat, input string tag);
    int k;
    k = 1;
    while (bus.rsp_valid !== 1'b1 && k < 80) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_result"}, bus.rsp_result, exp_res);
    check({tag, "_alu_idle"}, 32'(bus.alu_opcode), 32'h0);
    last_result = exp_res;
  endtask

  task automatic release_rsp(input logic [31:0] exp_res, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_result"}, bus.rsp_result, exp_res);
      check({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_post_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int hold, input string tag);
    logic is_shift;
    is_shift = (f3 == 3'd1 || f3 == 3'd5);
    bus.rsp_ready = (hold == 0);
    accept_req(f3, f7, a, b, tag);
    check({tag, "_exec_opcode"}, 32'(bus.alu_opcode), is_shift ? 32'h0 : ref_opcode(f3, f7));
    check({tag, "_exec_a"}, bus.alu_input_a, is_shift ? 32'h0 : a);
    check({tag, "_exec_b"}, bus.alu_input_b, is_shift ? 32'h0 : b);
    wait_rsp(exp_res, exp_lat, tag);
    release_rsp(exp_res, hold, tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic saw_valid;
    logic [2:0]  rf3;
    logic        rf7;
    logic [31:0] ra, rb;

    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_funct7b5 = 1'b0;
    bus.req_op_a = '0; bus.req_op_b = '0; bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'h0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1 check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Directed ops (expected values written out by hand)
    run_op(3'd0, 1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002, 2, 0, "add");
    run_op(3'd0, 1'b1, 32'd3, 32'd3, 32'h0, 2, 0, "sub");
    run_op(3'd2, 1'b0, 32'h8000_0000, 32'd1, 32'd1, 2, 0, "slt_sign");
    run_op(3'd3, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 2, 0, "sltu_sign");
    run_op(3'd2, 1'b0, 32'd5, 32'd7, 32'd1, 2, 0, "slt_neg");
    run_op(3'd3, 1'b0, 32'd7, 32'd5, 32'd0, 2, 0, "sltu_neg");
    run_op(3'd5, 1'b1, 32'h8000_00F0, 32'd4, 32'hF800_000F, 6, 0, "sra4");
    run_op(3'd5, 1'b0, 32'h8000_00F0, 32'd4, 32'h0800_000F, 6, 0, "srl4");
    run_op(3'd1, 1'b0, 32'd1, 32'd31, 32'h8000_0000, 33, 0, "sll31");
    run_op(3'd1, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 2, 0, "sll0");

    // Backpressure
    run_op(3'd4, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 2, 5, "xor_bp");

    // flush during SHIFT
    accept_req(3'd1, 1'b0, 32'h3, 32'd20, "flush_sll");
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("flush_rsp_result_kept", bus.rsp_result, last_result);
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw_valid |= bus.rsp_valid;
    end
    check("flush_no_rsp", 32'(saw_valid), 32'd0);
    run_op(3'd6, 1'b0, 32'hA, 32'h5, 32'hF, 2, 0, "or_after_flush");

    // Asynchronous reset mid-EXEC
    accept_req(3'd0, 1'b0, 32'd9, 32'd1, "rst_exec");
    check("rst_exec_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec_busy", 32'(busy), 32'd0);
    check("rst_exec_alu_opcode", 32'(bus.alu_opcode), 32'h0);
    check("rst_exec_alu_a", bus.alu_input_a, 32'h0);
    check("rst_exec_rsp_result", bus.rsp_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_valid |= bus.rsp_valid;
    end
    check("rst_exec_no_rsp", 32'(saw_valid), 32'd0);

    // Asynchronous reset mid-DONE
    bus.rsp_ready = 1'b0;
    accept_req(3'd4, 1'b0, 32'h1234_0000, 32'h0000_5678, "rst_done");
    wait_rsp(32'h1234_5678, 2, "rst_done");
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_done_rsp_result", bus.rsp_result, 32'h0);
    check("rst_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // Request held during flush in IDLE: accepted only once flush drops
    @(negedge clk);
    drive_req(3'd0, 1'b0, 32'd2, 32'd3);
    flush = 1'b1;
    #1 check("flush_idle_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("flush_idle_not_accepted", 32'(busy), 32'd0);
    flush = 1'b0;
    #1 check("flush_idle_ready_after", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("flush_idle_accepted", 32'(busy), 32'd1);
    wait_rsp(32'd5, 2, "flush_idle_add");
    release_rsp(32'd5, 0, "flush_idle_add");

    // Randomised ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      rf7 = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 4 == 0) ra[31] = rb[31];
      run_op(rf3, rf7, ra, rb, ref_result(rf3, rf7, ra, rb), ref_latency(rf3, rb),
             int'($urandom_range(0, 2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the core's single-cycle integer ALU. It accepts one RV32I register/immediate arithmetic request per handshake and decodes funct3/funct7[5] into the ALU 4-bit opcode.
- It drives the ALU operands, then builds the final result: directly for ADD/SUB/XOR/OR/AND, from ALU SUB flags for SLT/SLTU, and iteratively in-block for SLL/SRL/SRA, which the ALU does not implement.
- It sits between the decode/issue stage and writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHIFT_STEP, 1, bits shifted per cycle in SHIFT state; legal values are 1, 2, 4, 8.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight operation
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept request
- req_funct3  input  3  RV32I funct3
- req_funct7b5  input  1  instruction bit 30 (SUB/SRA select)
- req_op_a  input  32  rs1 value
- req_op_b  input  32  rs2 value or immediate; shamt = req_op_b[4:0]
- alu_opcode  output  4  to ALU: 0000 ADD, 0100 XOR, 0110 OR, 0111 AND, 1000 SUB
- alu_input_a  output  32  ALU operand A
- alu_input_b  output  32  ALU operand B
- alu_output  input  32  ALU result
- alu_neg  input  1  ALU result bit 31
- alu_zero  input  1  ALU result == 0 (unused, reserved)
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_result  output  32  final result
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; rsp_valid=0, rsp_result=0.
  - alu_opcode=0000, alu_input_a/b=0.
  - Internal operand, shift and count registers are 0.
  - req_ready=1 once rst_n is high.
- States are IDLE, EXEC, SHIFT and DONE.
- IDLE:
  - req_ready = !flush.
  - On req_valid&&req_ready, latch op_a, op_b, funct3 and funct7b5.
  - funct3 001/101 -> SHIFT, count = op_b[4:0], shift reg = op_a. All other funct3 -> EXEC.
- Decode:
  - 000: ADD, or SUB if funct7b5.
  - 100: XOR. 110: OR. 111: AND.
  - 010 and 011: SUB.
  - 001: SLL, funct7b5 ignored.
  - 101: SRL, or SRA if funct7b5.
- EXEC (exactly 1 cycle):
  - alu_opcode/alu_input_a/alu_input_b are driven from the latched values, registered so they are stable for the whole cycle.
  - At the end of the cycle, capture rsp_result and go to DONE.
  - ADD/SUB/XOR/OR/AND: result = alu_output.
  - SLT: if a[31]!=b[31], result = {31'b0, a[31]}; else result = {31'b0, alu_neg}.
  - SLTU: if a[31]!=b[31], result = {31'b0, b[31]}; else result = {31'b0, alu_neg}.
- ALU drive outside EXEC: alu_opcode=0000 and alu_input_a/b=0 in every state except EXEC.
- SHIFT:
  - If count==0, rsp_result = shift reg and go to DONE.
  - Otherwise step = min(SHIFT_STEP, count), shift by step and count -= step.
  - SLL fills 0. SRL fills 0. SRA fills the latched op_a[31].
  - SHIFT lasts ceil(shamt/SHIFT_STEP)+1 cycles; shamt=0 takes 1 cycle.
- DONE:
  - rsp_valid=1 and rsp_result is held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, rsp_valid=0 next cycle and go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Latency from accept edge to rsp_valid high:
  - Non-shift ops: 2 cycles.
  - Shifts: ceil(shamt/SHIFT_STEP)+2 cycles.
- Throughput: at most one op per 3 cycles, with rsp_ready held high.
- flush:
  - From any state, next state is IDLE and rsp_valid=0. The latched op is discarded and rsp_result keeps its old value.
  - flush and req_valid in IDLE in the same cycle: not accepted.
  - flush in DONE with rsp_ready in the same cycle: counts as flush, not a delivered response.
- rst_n asserted mid-operation: immediate return to reset values; no response is produced.
- req_* inputs are ignored outside IDLE; changing them after accept has no effect.
- busy = (state != IDLE).

Test Plan:
- Reset, then ADD a=0x0000_0005 b=0xFFFF_FFFD, rsp_ready=1 -> alu_opcode=0000 in EXEC; rsp_valid 2 cycles after accept; rsp_result=0x0000_0002; req_ready back to 1 the following cycle.
- SUB with funct7b5=1, a=3, b=3 -> rsp_result=0. SLT a=0x8000_0000 b=1 -> 1. SLTU same operands -> 0. SLT a=5 b=7 -> 1 (alu_neg path). SLTU a=7 b=5 -> 0.
- SHIFT_STEP=1, SRA a=0x8000_00F0 shamt=4 -> rsp_result=0xF800_000F, rsp_valid 6 cycles after accept. SRL with same inputs -> 0x0800_000F. SLL a=1 shamt=31 -> 0x8000_0000 after 33 cycles. SLL shamt=0 -> a unchanged after 2 cycles.
- Backpressure: XOR a=0xFF00_FF00 b=0x0FF0_0FF0 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result=0xF0F0_F0F0 held stable, req_ready=0 and busy=1 throughout; release rsp_ready -> IDLE next cycle.
- flush during SHIFT (SLL shamt=20, flush at cycle 5) -> IDLE next cycle, rsp_valid never rises. Next OR a=0xA b=0x5 -> 0xF with normal latency.
- rst_n pulled low asynchronously mid-EXEC and mid-DONE -> all outputs reset immediately, no response. Request held on req_valid during flush in IDLE -> accepted only in the first cycle after flush deasserts.
